// File: rtl/bch_result_scoreboard.sv
// bch_result_scoreboard: in-order checker for BCH decoder results.
// Each pushed frame carries its expected error pattern. Three independently timed checkers
// (errors-present flag, error count, reassembled locator vector) retire the frame in order.
// A slot is reused only once all three checkers have moved past it.
// Optional feature macro: BCH_SCOREBOARD_FIRST_FAIL_EN. When defined, the slot index and frame id
// of the first failure are captured in fail_tag, and the failing fields in fail_field.
// When undefined, both outputs are tied to zero.
module bch_result_scoreboard #(
  parameter int unsigned DW    = 16,
  parameter int unsigned BITS  = 1,
  parameter int unsigned CW    = 5,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SW    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [DW-1:0]               push_err,
  input  logic                        pres_valid,
  input  logic                        pres_in,
  input  logic                        cnt_valid,
  input  logic [CW-1:0]               cnt_in,
  input  logic                        err_first,
  input  logic                        err_valid,
  input  logic                        err_last,
  input  logic [BITS-1:0]             err,
  output logic                        full,
  output logic                        empty,
  output logic                        wrong,
  output logic                        overflow,
  output logic                        underflow,
  output logic [SW-1:0]               frames_checked,
  output logic [SW-1:0]               mismatches,
  output logic [$clog2(DEPTH)+SW-1:0] fail_tag,
  output logic [2:0]                  fail_field
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned SW1 = SW + 1;

  // Parameter sanity; an illegal configuration stops elaboration.
  if ((DW % BITS) != 0) begin : g_bad_bits
    $error("bch_result_scoreboard: DW must be a multiple of BITS");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("bch_result_scoreboard: DEPTH must be a power of 2 and at least 2");
  end
  if ((2 ** CW) <= DW) begin : g_bad_cw
    $error("bch_result_scoreboard: CW too narrow to hold popcount(DW)");
  end

  function automatic logic [CW-1:0] popcount(input logic [DW-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(DW); i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [PW-1:0] max3(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                         input logic [PW-1:0] c);
    logic [PW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Frame storage; popcount and OR are precomputed at push time.
  logic [DW-1:0] err_mem  [DEPTH];
  logic [CW-1:0] cnt_mem  [DEPTH];
  logic          pres_mem [DEPTH];

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rp_pres_q, rp_pres_d;
  logic [PW-1:0] rp_cnt_q, rp_cnt_d;
  logic [PW-1:0] rp_vec_q, rp_vec_d;
  logic [AW-1:0] wr_idx, pres_idx, cnt_idx, vec_idx;

  logic [PW-1:0] occ_pres, occ_cnt, occ_vec, occ_max, occ_max_d;
  logic [PW-1:0] slow_q, slow_d;
  logic          retire;

  logic [DW-1:0] vbuf_q, vbuf_d, beat_top;
  logic          vec_done_q;

  logic          push_ok, push_ovf;
  logic          pres_go, pres_unf, pres_mis;
  logic          cnt_go, cnt_unf, cnt_mis;
  logic          vec_go, vec_unf, vec_mis;
  logic          fail_event;
  logic [1:0]    mis_n;
  logic [SW:0]   mis_sum;

  logic          wrong_q, overflow_q, underflow_q;
  logic [SW-1:0] frames_checked_q, frames_checked_d;
  logic [SW-1:0] mismatches_q, mismatches_d;

  assign wr_idx   = wr_q[AW-1:0];
  assign pres_idx = rp_pres_q[AW-1:0];
  assign cnt_idx  = rp_cnt_q[AW-1:0];
  assign vec_idx  = rp_vec_q[AW-1:0];

  assign occ_pres = wr_q - rp_pres_q;
  assign occ_cnt  = wr_q - rp_cnt_q;
  assign occ_vec  = wr_q - rp_vec_q;
  assign occ_max  = max3(occ_pres, occ_cnt, occ_vec);

  assign full  = (occ_max == PW'(DEPTH));
  assign empty = (occ_pres == '0) && (occ_cnt == '0) && (occ_vec == '0);

  // A push in this cycle is not yet visible to the checkers, so strobes only see wr_q.
  assign push_ok  = push && !full;
  assign push_ovf = push && full;

  assign pres_go  = pres_valid && (occ_pres != '0);
  assign pres_unf = pres_valid && (occ_pres == '0);
  assign pres_mis = pres_go && (pres_in != pres_mem[pres_idx]);

  assign cnt_go   = cnt_valid && (occ_cnt != '0);
  assign cnt_unf  = cnt_valid && (occ_cnt == '0);
  assign cnt_mis  = cnt_go && (cnt_in != cnt_mem[cnt_idx]);

  assign vec_go   = vec_done_q && (occ_vec != '0);
  assign vec_unf  = vec_done_q && (occ_vec == '0);
  assign vec_mis  = vec_go && (vbuf_q != err_mem[vec_idx]);

  assign fail_event = push_ovf || pres_unf || cnt_unf || vec_unf ||
                      pres_mis || cnt_mis || vec_mis;

  // Next pointer values and retirement of the slowest checker.
  always_comb begin
    wr_d      = wr_q + PW'(push_ok);
    rp_pres_d = rp_pres_q + PW'(pres_go);
    rp_cnt_d  = rp_cnt_q + PW'(cnt_go);
    rp_vec_d  = rp_vec_q + PW'(vec_go);
    occ_max_d = max3(wr_d - rp_pres_d, wr_d - rp_cnt_d, wr_d - rp_vec_d);
    slow_q    = wr_q - occ_max;
    slow_d    = wr_d - occ_max_d;
    retire    = (slow_d != slow_q);
  end

  // Locator beats enter at the top of vbuf; the first beat ends up in the LSBs.
  always_comb begin
    beat_top = DW'(err) << (DW - BITS);
    vbuf_d   = vbuf_q;
    if (err_first) begin
      vbuf_d = beat_top;
    end else if (err_valid) begin
      vbuf_d = beat_top | (vbuf_q >> BITS);
    end
  end

  // Saturating statistics counters.
  always_comb begin
    mis_n   = 2'(pres_mis) + 2'(cnt_mis) + 2'(vec_mis);
    mis_sum = {1'b0, mismatches_q} + SW1'(mis_n);
    mismatches_d = mis_sum[SW] ? '1 : mis_sum[SW-1:0];
    frames_checked_d = frames_checked_q;
    if (retire && (frames_checked_q != '1)) begin
      frames_checked_d = frames_checked_q + 1'b1;
    end
  end

  // Entry write; storage needs no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      err_mem[wr_idx]  <= push_err;
      cnt_mem[wr_idx]  <= popcount(push_err);
      pres_mem[wr_idx] <= |push_err;
    end
  end

  // Pointers, reassembly state, sticky flags and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q             <= '0;
      rp_pres_q        <= '0;
      rp_cnt_q         <= '0;
      rp_vec_q         <= '0;
      vbuf_q           <= '0;
      vec_done_q       <= 1'b0;
      wrong_q          <= 1'b0;
      overflow_q       <= 1'b0;
      underflow_q      <= 1'b0;
      frames_checked_q <= '0;
      mismatches_q     <= '0;
    end else begin
      wr_q             <= wr_d;
      rp_pres_q        <= rp_pres_d;
      rp_cnt_q         <= rp_cnt_d;
      rp_vec_q         <= rp_vec_d;
      vbuf_q           <= vbuf_d;
      vec_done_q       <= err_last;
      wrong_q          <= wrong_q | fail_event;
      overflow_q       <= overflow_q | push_ovf;
      underflow_q      <= underflow_q | pres_unf | cnt_unf | vec_unf;
      frames_checked_q <= frames_checked_d;
      mismatches_q     <= mismatches_d;
    end
  end

  assign wrong          = wrong_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;
  assign frames_checked = frames_checked_q;
  assign mismatches     = mismatches_q;

`ifdef BCH_SCOREBOARD_FIRST_FAIL_EN
  logic [SW-1:0]    id_q;
  logic [SW-1:0]    id_mem [DEPTH];
  logic [AW+SW-1:0] fail_tag_q, fail_tag_d;
  logic [2:0]       fail_field_q, fail_field_d;

  // Frame id counts accepted pushes and wraps at SW bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q <= '0;
    end else if (push_ok) begin
      id_q <= id_q + 1'b1;
    end
  end

  // Per-entry frame id, written alongside the expected pattern.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      id_mem[wr_idx] <= id_q;
    end
  end

  // Capture only the first failure; when several fields fail together the vector entry wins.
  always_comb begin
    fail_tag_d   = fail_tag_q;
    fail_field_d = fail_field_q;
    if (!wrong_q && fail_event) begin
      if (vec_mis) begin
        fail_tag_d = {vec_idx, id_mem[vec_idx]};
      end else if (cnt_mis) begin
        fail_tag_d = {cnt_idx, id_mem[cnt_idx]};
      end else if (pres_mis) begin
        fail_tag_d = {pres_idx, id_mem[pres_idx]};
      end else begin
        fail_tag_d = {wr_idx, id_q};
      end
      fail_field_d = {vec_mis, cnt_mis, pres_mis};
    end
  end

  // First-failure record register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_tag_q   <= '0;
      fail_field_q <= '0;
    end else begin
      fail_tag_q   <= fail_tag_d;
      fail_field_q <= fail_field_d;
    end
  end

  assign fail_tag   = fail_tag_q;
  assign fail_field = fail_field_q;
`else
  assign fail_tag   = '0;
  assign fail_field = '0;
`endif

endmodule

// File: tb/tb_bch_result_scoreboard.sv
// tb_bch_result_scoreboard: cycle-level scoreboard bench for bch_result_scoreboard.
// Expected frames are queued per checker as they are pushed and popped when the matching
// result strobe is driven; status outputs are compared against the bench model at checkpoints.
module tb_bch_result_scoreboard;

  localparam int unsigned DW    = 16;
  localparam int unsigned BITS  = 4;
  localparam int unsigned CW    = 5;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SW    = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned NB    = DW / BITS;

`ifdef BCH_SCOREBOARD_FIRST_FAIL_EN
  localparam bit FfEn = 1'b1;
`else
  localparam bit FfEn = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] pat;
    int unsigned   idx;
  } frame_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              push;
  logic [DW-1:0]     push_err;
  logic              pres_valid;
  logic              pres_in;
  logic              cnt_valid;
  logic [CW-1:0]     cnt_in;
  logic              err_first;
  logic              err_valid;
  logic              err_last;
  logic [BITS-1:0]   err;
  logic              full;
  logic              empty;
  logic              wrong;
  logic              overflow;
  logic              underflow;
  logic [SW-1:0]     frames_checked;
  logic [SW-1:0]     mismatches;
  logic [AW+SW-1:0]  fail_tag;
  logic [2:0]        fail_field;

  bch_result_scoreboard #(
    .DW    (DW),
    .BITS  (BITS),
    .CW    (CW),
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .push_err       (push_err),
    .pres_valid     (pres_valid),
    .pres_in        (pres_in),
    .cnt_valid      (cnt_valid),
    .cnt_in         (cnt_in),
    .err_first      (err_first),
    .err_valid      (err_valid),
    .err_last       (err_last),
    .err            (err),
    .full           (full),
    .empty          (empty),
    .wrong          (wrong),
    .overflow       (overflow),
    .underflow      (underflow),
    .frames_checked (frames_checked),
    .mismatches     (mismatches),
    .fail_tag       (fail_tag),
    .fail_field     (fail_field)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  // Scoreboard / model state.
  frame_t           q_pres[$];
  frame_t           q_cnt[$];
  frame_t           q_vec[$];
  int unsigned      wr_n, pres_n, cnt_n, vec_n;
  int unsigned      exp_checked, exp_mism;
  bit               exp_wrong, exp_ovf, exp_unf;
  logic [AW+SW-1:0] exp_tag;
  logic [2:0]       exp_field;
  bit               vec_due;
  logic [DW-1:0]    vec_sent;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [AW+SW-1:0] mk_tag(input int unsigned idx);
    logic [AW-1:0] slot;
    logic [SW-1:0] id;
    slot = AW'(idx % DEPTH);
    id   = SW'(idx);
    return {slot, id};
  endfunction

  function automatic int unsigned min3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  task automatic clear_inputs();
    push       = 1'b0;
    push_err   = '0;
    pres_valid = 1'b0;
    pres_in    = 1'b0;
    cnt_valid  = 1'b0;
    cnt_in     = '0;
    err_first  = 1'b0;
    err_valid  = 1'b0;
    err_last   = 1'b0;
    err        = '0;
  endtask

  task automatic model_reset();
    q_pres.delete();
    q_cnt.delete();
    q_vec.delete();
    wr_n = 0; pres_n = 0; cnt_n = 0; vec_n = 0;
    exp_checked = 0; exp_mism = 0;
    exp_wrong = 0; exp_ovf = 0; exp_unf = 0;
    exp_tag = '0; exp_field = '0;
    vec_due = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Apply this cycle's driven inputs to the model, then clock the DUT once.
  task automatic step();
    int unsigned      occ_max, ret_b, ret_a, sum;
    bit               pm, cm, vm, fail;
    logic [AW+SW-1:0] tag, tag_p, tag_c, tag_v;
    frame_t           f;
    occ_max = wr_n - pres_n;
    if (wr_n - cnt_n > occ_max) occ_max = wr_n - cnt_n;
    if (wr_n - vec_n > occ_max) occ_max = wr_n - vec_n;
    ret_b = min3(pres_n, cnt_n, vec_n);
    pm = 0; cm = 0; vm = 0; fail = 0;
    tag = mk_tag(wr_n); tag_p = '0; tag_c = '0; tag_v = '0;
    if (pres_valid) begin
      if (q_pres.size() == 0) begin exp_unf = 1; fail = 1; end
      else begin
        f = q_pres.pop_front(); pres_n++;
        pm = (pres_in != (f.pat != '0));
        tag_p = mk_tag(f.idx);
      end
    end
    if (cnt_valid) begin
      if (q_cnt.size() == 0) begin exp_unf = 1; fail = 1; end
      else begin
        f = q_cnt.pop_front(); cnt_n++;
        cm = (cnt_in != CW'($countones(f.pat)));
        tag_c = mk_tag(f.idx);
      end
    end
    if (vec_due) begin
      if (q_vec.size() == 0) begin exp_unf = 1; fail = 1; end
      else begin
        f = q_vec.pop_front(); vec_n++;
        vm = (vec_sent != f.pat);
        tag_v = mk_tag(f.idx);
      end
    end
    if (push) begin
      if (occ_max == DEPTH) begin exp_ovf = 1; fail = 1; end
      else begin
        f.pat = push_err; f.idx = wr_n;
        q_pres.push_back(f); q_cnt.push_back(f); q_vec.push_back(f);
        wr_n++;
      end
    end
    sum = exp_mism + int'(pm) + int'(cm) + int'(vm);
    exp_mism = (sum > 65535) ? 65535 : sum;
    if (fail || pm || cm || vm) begin
      if (!exp_wrong) begin
        if (vm) tag = tag_v;
        else if (cm) tag = tag_c;
        else if (pm) tag = tag_p;
        exp_tag = tag;
        exp_field = {vm, cm, pm};
      end
      exp_wrong = 1;
    end
    ret_a = min3(pres_n, cnt_n, vec_n);
    if (exp_checked < 65535) exp_checked += ret_a - ret_b;
    @(posedge clk); #1;
    vec_due = err_last;
    clear_inputs();
  endtask

  task automatic check_all(input string tag);
    int unsigned om;
    om = wr_n - pres_n;
    if (wr_n - cnt_n > om) om = wr_n - cnt_n;
    if (wr_n - vec_n > om) om = wr_n - vec_n;
    check({tag, ".full"}, 64'(full), 64'(om == DEPTH));
    check({tag, ".empty"}, 64'(empty),
          64'((wr_n == pres_n) && (wr_n == cnt_n) && (wr_n == vec_n)));
    check({tag, ".wrong"}, 64'(wrong), 64'(exp_wrong));
    check({tag, ".overflow"}, 64'(overflow), 64'(exp_ovf));
    check({tag, ".underflow"}, 64'(underflow), 64'(exp_unf));
    check({tag, ".checked"}, 64'(frames_checked), 64'(exp_checked));
    check({tag, ".mism"}, 64'(mismatches), 64'(exp_mism));
    check({tag, ".fail_tag"}, 64'(fail_tag), FfEn ? 64'(exp_tag) : 64'd0);
    check({tag, ".fail_field"}, 64'(fail_field), FfEn ? 64'(exp_field) : 64'd0);
  endtask

  task automatic do_push(input logic [DW-1:0] pat);
    push = 1'b1; push_err = pat; step();
  endtask

  // Drive a locator vector LSB beat first; the compare lands in the cycle after the last beat.
  task automatic send_vec(input logic [DW-1:0] v);
    vec_sent = v;
    for (int k = 0; k < int'(NB); k++) begin
      err_first = (k == 0);
      err_valid = 1'b1;
      err_last  = (k == int'(NB) - 1);
      err       = v[k*BITS +: BITS];
      step();
    end
  endtask

  task automatic run_frame(input logic [DW-1:0] pat, input logic pv, input logic [CW-1:0] cv,
                           input logic [DW-1:0] vv);
    do_push(pat);
    pres_valid = 1'b1; pres_in = pv; cnt_valid = 1'b1; cnt_in = cv; step();
    send_vec(vv);
    step();
  endtask

  logic [DW-1:0] pats [8];

  initial begin
    clear_inputs();
    vec_sent = '0;
    model_reset();
    do_reset();
    check_all("reset");

    // Single good frame, then a count mismatch with a passing vector.
    run_frame(16'h0005, 1'b1, 5'd2, 16'h0005);
    check_all("good");
    run_frame(16'h8001, 1'b1, 5'd3, 16'h8001);
    check_all("cnt_bad");

    // Fill to DEPTH, then one push too many.
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) do_push(DW'(i * 3 + 1));
    check_all("filled");
    do_push(16'hffff);
    check_all("ovf");

    // Underflow on an empty count checker, then a clean frame.
    do_reset();
    cnt_valid = 1'b1; cnt_in = 5'd1; step();
    check_all("unf");
    run_frame(16'h0030, 1'b1, 5'd2, 16'h0030);
    check_all("after_unf");

    // Skewed checkers; the last push lands in the same cycle as the first vector compare.
    do_reset();
    for (int i = 0; i < 8; i++) pats[i] = DW'($urandom);
    for (int i = 0; i < 7; i++) do_push(pats[i]);
    for (int i = 0; i < 7; i++) begin
      pres_valid = 1'b1; pres_in = |pats[i];
      cnt_valid = 1'b1; cnt_in = CW'($countones(pats[i]));
      step();
    end
    check_all("skew_pre");
    send_vec(pats[0]);
    push = 1'b1; push_err = pats[7]; step();
    check_all("skew_swap");
    pres_valid = 1'b1; pres_in = |pats[7];
    cnt_valid = 1'b1; cnt_in = CW'($countones(pats[7]));
    step();
    for (int i = 1; i < 8; i++) begin
      send_vec(pats[i]);
      step();
    end
    check_all("skew_done");

    // Several fields mismatching in one cycle.
    do_reset();
    do_push(16'h00f0);
    do_push(16'h0f00);
    pres_valid = 1'b1; pres_in = 1'b0; cnt_valid = 1'b1; cnt_in = 5'd7; step();
    check_all("multi2");
    send_vec(16'h00f1);
    pres_valid = 1'b1; pres_in = 1'b0; cnt_valid = 1'b1; cnt_in = 5'd0; step();
    check_all("multi3");

    // First-failure capture: wrong vector on frame 3, wrong count on frame 5.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic [DW-1:0] p;
      p = DW'(16'h0101 * (i + 1));
      run_frame(p, 1'b1, CW'($countones(p)) + ((i == 5) ? 5'd1 : 5'd0),
                (i == 3) ? (p ^ 16'h0010) : p);
`ifdef BCH_SCOREBOARD_FIRST_FAIL_EN
      if (i == 3) begin
        check("ff3.tag", 64'(fail_tag), 64'({3'd3, 16'd3}));
        check("ff3.field", 64'(fail_field), 64'(3'b100));
      end
`endif
    end
    check_all("ff_end");
    do_reset();
    check_all("ff_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bch_result_scoreboard.md
Name: bch_result_scoreboard

Overview:
- Parametrised self-checking scoreboard for BCH decode-chain testbenches and FPGA BIST.
- Queues the expected error pattern of each encoded frame, then checks three independently timed decoder results in order: errors-present flag, error count, and the reassembled error-location vector.
- Sits beside the encoder/syndrome/key-solver/locator chain. It is shared by the serial, parallel and DEC flows.

Parameters:
- DW, 16, expected error-vector width (data bits per frame).
- BITS, 1, locator output bits per cycle; DW % BITS == 0 is required, else elaboration fails.
- CW, 5, error-count width; must hold popcount(DW).
- DEPTH, 16, frames in flight; power of 2, >= 2.
- SW, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- push  in  1  enqueue an expected frame
- push_err  in  DW  expected error pattern
- pres_valid  in  1  errors-present result strobe
- pres_in  in  1  decoder errors-present flag
- cnt_valid  in  1  error-count result strobe
- cnt_in  in  CW  decoder error count
- err_first  in  1  first locator beat
- err_valid  in  1  locator beat valid (asserted with err_first)
- err_last  in  1  final locator beat
- err  in  BITS  locator beat data
- full  out  1  queue full
- empty  out  1  no frame pending on any checker
- wrong  out  1  sticky failure
- overflow  out  1  sticky push-while-full
- underflow  out  1  sticky result with no pending frame
- frames_checked  out  SW  frames fully retired
- mismatches  out  SW  field mismatches
- fail_tag  out  log2(DEPTH)+SW  first failing frame id (feature)
- fail_field  out  3  {vec,cnt,pres} of first failure (feature)

Behaviour:
- Storage: DEPTH entries of {err[DW], popcount[CW], |err}. Popcount and OR are computed at push time.
- Pointers: log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
  - One write pointer.
  - Three read pointers: rp_pres, rp_cnt, rp_vec.
  - Each checker's occupancy is wr - rp_x.
- Full/empty:
  - full = max occupancy == DEPTH.
  - empty = all occupancies == 0.
- Push:
  - When push && !full, write the entry and increment wr.
  - When push && full, drop the entry, set overflow, set wrong.
- Presence and count checks:
  - On pres_valid, compare against entry[rp_pres]; on cnt_valid, compare against entry[rp_cnt].
  - Each strobe advances its pointer by 1 when occupancy > 0.
  - If occupancy is 0, set underflow, set wrong, leave the pointer unchanged, and do no compare.
  - Mismatch sets wrong and increments mismatches (saturating).
- Vector reassembly into a DW shift register vbuf:
  - err_first: vbuf <= err << (DW-BITS).
  - err_valid && !err_first: vbuf <= (err << (DW-BITS)) | (vbuf >> BITS).
  - vec_done <= err_last (registered). The compare uses vbuf against entry[rp_vec] in the vec_done cycle, then rp_vec advances.
  - The result is visible in wrong one cycle after vec_done, i.e. 2 cycles after err_last.
- Simultaneous events:
  - Any mix of push and the three result strobes may occur in one cycle.
  - A push in the same cycle as a result strobe with occupancy 0 still underflows: the new entry is not visible until the next cycle.
  - Simultaneous mismatches on several fields add their total to mismatches, saturating.
- Retirement:
  - frames_checked increments (saturating) whenever the slowest read pointer advances.
  - A slot is reusable only after all three pointers pass it.
- Reset: all pointers, vbuf, vec_done, counters and sticky flags go to 0. full=0, empty=1. Reset mid-frame discards all in-flight state.
- wrong, overflow and underflow are sticky until reset.

Optional Feature:
- Macro: BCH_SCOREBOARD_FIRST_FAIL_EN.
- Defined:
  - A frame id (push count, SW bits, wrapping) is stored per entry.
  - On the first failure after reset, fail_tag <= {slot index, frame id} of the failing entry and fail_field <= the fields that mismatched that cycle. Both then hold until reset.
  - Overflow/underflow failures record the write-side id with fail_field = 0.
- Undefined: fail_tag and fail_field are tied to 0, and the per-entry id storage is not instantiated.

Test Plan:
- DW=16,BITS=1: push 0x0005; pres_in=1, cnt_in=2 strobes; 16 beats with err bits 1,0,1,0…0 (LSB first) -> wrong=0, frames_checked=1, mismatches=0.
- DW=16,BITS=4: push 0x8001, four beats 1,0,0,8 with cnt_in=3 -> cnt mismatch, mismatches=1, wrong=1; vector check passes.
- DEPTH=4: push 5 frames with no results -> full=1 after 4 pushes, overflow=1 on the 5th; frames_checked stays 0.
- cnt_valid with empty=1 -> underflow=1, wrong=1, rp_cnt unchanged; a following push+check still compares correctly.
- Skewed timing, DEPTH=8: 8 frames; pres checker 7 ahead of vec checker, and a push issued in the same cycle as the vec check frees a slot -> no overflow, all 8 pass, final empty=1.
- FIRST_FAIL_EN: frame 3 has a wrong vector and frame 5 a wrong count -> fail_tag id=3, fail_field=3'b100, unchanged after frame 5; reset clears it to 0.
